bird_ctl: RTL



---
 rtl/game_pkg.sv | 18 +
 rtl/bird_ctl.sv | 65 ++++++
 2 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared game state encoding, screen geometry and bird physics constants
//   game_state_t : 2-bit FSM state shared between the game FSM and bird_ctl
//   SCREEN_H, BIRD_H : screen height and bird sprite height in pixels
//   Y_START, Y_MAX, GRAVITY, FLAP_VEL, V_TERM : default bird physics constants
package game_pkg;
    typedef enum logic [1:0] {
        START    = 2'b00,
        GAME     = 2'b01,
        GAMEOVER = 2'b10
    } game_state_t;
    localparam int SCREEN_H = 480;
    localparam int BIRD_H   = 24;
    localparam int Y_START  = 228;
    localparam int Y_MAX    = SCREEN_H - BIRD_H;
    localparam int GRAVITY  = 1;
    localparam int FLAP_VEL = -8;
    localparam int V_TERM   = 10;
endpackage

// File: rtl/bird_ctl.sv
// bird_ctl: per-frame vertical motion of the bird sprite with sticky boundary-hit flag
//   clk, rst_n      : clock, asynchronous active-low reset
//   frame_tick      : one-cycle pulse per video frame
//   state           : game FSM state (only GAME advances physics)
//   game_rst        : synchronous restart of bird position, velocity and hit flag
//   mouse_left_game : flap request, latched until the next GAME frame tick
//   bird_y          : bird top-edge Y in pixels
//   bird_vel        : signed velocity in px/frame
//   bound_hit       : sticky ceiling/floor contact flag
module bird_ctl
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic [1:0] state,
    input  logic       game_rst,
    input  logic       mouse_left_game,
    output logic [9:0] bird_y,
    output logic [5:0] bird_vel,
    output logic       bound_hit
);
    logic              flap_pend;
    logic              step;
    logic signed [6:0] v_inc;
    logic signed [6:0] v_new;
    logic signed [11:0] y_new;
    logic [9:0]        y_nxt;
    logic [5:0]        vel_nxt;
    logic              hit_nxt;

    // Velocity and position use widened signed arithmetic so neither the
    // gravity increment nor a position just past a boundary can wrap.
    always_comb begin
        step    = frame_tick && (game_state_t'(state) == GAME);
        v_inc   = 7'(signed'(bird_vel)) + 7'(GRAVITY);
        v_new   = flap_pend ? 7'(FLAP_VEL) : (v_inc > 7'(V_TERM) ? 7'(V_TERM) : v_inc);
        y_new   = signed'({2'b00, bird_y}) + 12'(v_new);
        y_nxt   = y_new < 0 ? 10'd0 : (y_new > 12'(Y_MAX) ? 10'(Y_MAX) : y_new[9:0]);
        vel_nxt = (y_new < 0 || y_new > 12'(Y_MAX)) ? 6'd0 : v_new[5:0];
        hit_nxt = bound_hit || y_new < 0 || y_new > 12'(Y_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bird_y    <= 10'(Y_START);
            bird_vel  <= 6'd0;
            bound_hit <= 1'b0;
            flap_pend <= 1'b0;
        end else if (game_rst) begin
            bird_y    <= 10'(Y_START);
            bird_vel  <= 6'd0;
            bound_hit <= 1'b0;
            flap_pend <= mouse_left_game;
        end else if (step) begin
            bird_y    <= y_nxt;
            bird_vel  <= vel_nxt;
            bound_hit <= hit_nxt;
            // A flap arriving on the consuming tick itself is kept for the next frame.
            flap_pend <= mouse_left_game;
        end else begin
            flap_pend <= flap_pend || mouse_left_game;
        end
    end
endmodule
